// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   typedef logic [1:0] state_t;

   // Bit counter must reach WIDTH without wrapping.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full-adder slice used by serial_adder.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder, LSB first, one full-adder slice plus carry flop.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic            ovf
`endif
);

   localparam int unsigned    CW   = cnt_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] sh_a;
   logic [WIDTH-1:0] sh_b;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             fa_s;
   logic             fa_c;
`ifdef SERIAL_ADDER_OVF_EN
   logic             msb_cin;
`endif

   full_adder u_fa (
      .a    (sh_a[0]),
      .b    (sh_b[0]),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_c)
   );

   // busy/done are registered views of the state, one cycle behind it,
   // so the result appears WIDTH+1 edges after acceptance.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         sh_a    <= '0;
         sh_b    <= '0;
         acc     <= '0;
         carry   <= 1'b0;
         cnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         msb_cin <= 1'b0;
         ovf     <= 1'b0;
`endif
      end else begin
         busy <= (state == SHIFT);
         done <= (state == DONE);
         case (state)
            IDLE: begin
               if (start) begin
                  sh_a  <= op_a;
                  sh_b  <= op_b;
                  carry <= 1'b0;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               sh_a  <= sh_a >> 1;
               sh_b  <= sh_b >> 1;
               acc   <= {fa_s, acc[WIDTH-1:1]};
               carry <= fa_c;
               cnt   <= cnt + CW'(1);
`ifdef SERIAL_ADDER_OVF_EN
               msb_cin <= carry;
`endif
               if (cnt == LAST)
                  state <= DONE;
            end
            DONE: begin
               sum   <= acc;
               cout  <= carry;
`ifdef SERIAL_ADDER_OVF_EN
               ovf   <= msb_cin ^ carry;
`endif
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8); ovf checks when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

   localparam int unsigned W = 8;

   logic         clock;
   logic         reset;
   logic         start;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif

   int vectors;
   int miscompares;

   serial_adder #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .start (start),
      .op_a  (op_a),
      .op_b  (op_b),
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,.ovf  (ovf)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_ovf(input string tag, input logic exp);
`ifdef SERIAL_ADDER_OVF_EN
      chk(tag, {31'd0, ovf}, {31'd0, exp});
`else
      if (exp === 1'bx) $display("unreachable %s", tag);
`endif
   endtask

   // Full transaction with cycle-exact busy/done timing checks.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] es, input logic ec, input logic eo);
      op_a  = a;
      op_b  = b;
      start = 1'b1;
      tick;
      start = 1'b0;
      op_a  = ~a;
      op_b  = ~b;
      chk("busy_after_accept", {31'd0, busy}, 32'd0);
      for (int unsigned k = 1; k <= W; k++) begin
         tick;
         chk("busy_shift", {31'd0, busy}, 32'd1);
         chk("done_low_shift", {31'd0, done}, 32'd0);
      end
      tick;
      chk("done_pulse", {31'd0, done}, 32'd1);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      chk("sum", {24'd0, sum}, {24'd0, es});
      chk("cout", {31'd0, cout}, {31'd0, ec});
      chk_ovf("ovf", eo);
      tick;
      chk("done_fall", {31'd0, done}, 32'd0);
      chk("sum_hold", {24'd0, sum}, {24'd0, es});
   endtask

   int ndone;
   int tdone[3];

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset = 1'b1;
      start = 1'b0;
      op_a  = '0;
      op_b  = '0;
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_sum", {24'd0, sum}, 32'd0);
      chk("reset_cout", {31'd0, cout}, 32'd0);
      chk_ovf("reset_ovf", 1'b0);
      tick;
      tick;
      reset = 1'b0;
      tick;

      run_op(8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
      run_op(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
      run_op(8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
      run_op(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);

      // start and new operands during busy must be ignored
      op_a  = 8'h05;
      op_b  = 8'h03;
      start = 1'b1;
      tick;
      start = 1'b0;
      tick;
      tick;
      tick;
      op_a  = 8'h11;
      op_b  = 8'h22;
      start = 1'b1;
      tick;
      start = 1'b0;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         tick;
         if (done) begin
            ndone++;
            chk("ignore_start_sum", {24'd0, sum}, 32'h08);
         end
      end
      chk("ignore_start_done_count", ndone, 32'd1);

      // reset mid-operation aborts and clears outputs asynchronously
      op_a  = 8'h21;
      op_b  = 8'h32;
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 4; i++) tick;
      chk("pre_abort_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_sum", {24'd0, sum}, 32'd0);
      chk("abort_cout", {31'd0, cout}, 32'd0);
      tick;
      reset = 1'b0;
      ndone = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (done) ndone++;
      end
      chk("abort_no_done", ndone, 32'd0);
      run_op(8'h0A, 8'h0B, 8'h15, 1'b0, 1'b0);

      // start held high: back-to-back operations every WIDTH+2 cycles
      op_a  = 8'h40;
      op_b  = 8'h40;
      start = 1'b1;
      ndone = 0;
      for (int n = 1; n <= 35; n++) begin
         tick;
         if (done) begin
            if (ndone < 3) tdone[ndone] = n;
            ndone++;
            chk("b2b_sum", {24'd0, sum}, 32'h80);
            chk("b2b_cout", {31'd0, cout}, 32'd0);
            chk_ovf("b2b_ovf", 1'b1);
         end
      end
      start = 1'b0;
      chk("b2b_done_count", ndone, 32'd3);
      if (ndone >= 3) begin
         chk("b2b_first_latency", tdone[0], 32'd10);
         chk("b2b_period_1", tdone[1] - tdone[0], 32'd10);
         chk("b2b_period_2", tdone[2] - tdone[1], 32'd10);
      end
      for (int i = 0; i < 12; i++) tick;
      chk("final_idle_busy", {31'd0, busy}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
